// File: rtl/input_port_buffer.sv
// Router input stage: flit FIFO plus a packet FSM that raises the arbiter request for
// the head packet and drains it one flit per granted, accepted cycle.
module input_port_buffer #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned FLIT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] in_flit,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              grant,
    input  logic              out_ready,
    output logic              req,
    output logic [2:0]        flit_id,
    output logic [11:0]       length,
    output logic [FLIT_W-1:0] out_flit,
    output logic              out_valid,
    output logic              drop_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [2:0]  ID_HEADER = 3'b001;
    localparam logic [2:0]  ID_TAIL   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [11:0]        len_q, len_d;
    logic [FLIT_W-1:0]  mem_q [DEPTH];

    logic              empty;
    logic              push;
    logic              pop;
    logic              drop;
    logic [FLIT_W-1:0] head;
    logic [2:0]        head_id;

    assign head     = mem_q[rd_ptr_q];
    assign head_id  = head[FLIT_W-1 -: 3];
    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CNT_W'(DEPTH));
    // A full FIFO refuses the push even if a pop frees a slot this cycle.
    assign push     = in_valid && in_ready;

    // Packet FSM: next state, pop decision and length capture.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        drop    = 1'b0;
        len_d   = len_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    if (head_id == ID_HEADER) begin
                        state_d = ST_REQ;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            ST_REQ: begin
                if (grant && out_ready) begin
                    pop     = 1'b1;
                    len_d   = head[11:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (grant && out_ready && !empty) begin
                    pop = 1'b1;
                    if (head_id == ID_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            len_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            len_q    <= len_d;
        end
    end

    // Storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_flit;
        end
    end

    assign req       = (state_q != ST_IDLE);
    assign flit_id   = empty ? 3'b000 : head_id;
    assign length    = (state_q == ST_REQ) ? head[11:0] : len_q;
    assign out_flit  = head;
    assign out_valid = pop && (state_q != ST_IDLE);
    assign drop_err  = drop;

endmodule

// File: tb/tb_input_port_buffer.sv
// Self-checking bench for input_port_buffer: directed scenarios plus random traffic
// compared each cycle against a queue-based packet model.
module tb_input_port_buffer;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned FLIT_W = 32;

    logic              clk;
    logic              rst;
    logic [FLIT_W-1:0] in_flit;
    logic              in_valid;
    logic              in_ready;
    logic              grant;
    logic              out_ready;
    logic              req;
    logic [2:0]        flit_id;
    logic [11:0]       length;
    logic [FLIT_W-1:0] out_flit;
    logic              out_valid;
    logic              drop_err;

    input_port_buffer #(.DEPTH(DEPTH), .FLIT_W(FLIT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_flit   (in_flit),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .grant     (grant),
        .out_ready (out_ready),
        .req       (req),
        .flit_id   (flit_id),
        .length    (length),
        .out_flit  (out_flit),
        .out_valid (out_valid),
        .drop_err  (drop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: buffered flits, packet phase (0 none, 1 header waiting, 2 sending), length.
    logic [FLIT_W-1:0] mq[$];
    int                phase   = 0;
    logic [11:0]       len_reg = '0;
    logic [FLIT_W-1:0] gq[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [FLIT_W-1:0] mk(input logic [2:0] id, input logic [28:0] pl);
        return {id, pl};
    endfunction

    function automatic logic [2:0] id_of(input logic [FLIT_W-1:0] f);
        return f[FLIT_W-1 -: 3];
    endfunction

    task automatic model_reset();
        mq.delete();
        phase   = 0;
        len_reg = '0;
    endtask

    // One clock: drive inputs just after an edge, check mid-cycle, advance model at the edge.
    task automatic do_cycle(input logic v, input logic [FLIT_W-1:0] f, input logic g,
                            input logic r, output logic acc);
        logic       e_pop;
        logic [2:0] e_id;
        logic [11:0] e_len;
        int         nphase;
        in_valid  = v;
        in_flit   = f;
        grant     = g;
        out_ready = r;
        #2;
        e_id  = (mq.size() != 0) ? id_of(mq[0]) : 3'b000;
        e_len = (phase == 1) ? mq[0][11:0] : len_reg;
        case (phase)
            0:       e_pop = (mq.size() != 0) && (e_id != 3'b001);
            1:       e_pop = g && r;
            default: e_pop = g && r && (mq.size() != 0);
        endcase
        check_eq("in_ready",  32'(in_ready),  32'(mq.size() != DEPTH));
        check_eq("req",       32'(req),       32'(phase != 0));
        check_eq("flit_id",   32'(flit_id),   32'(e_id));
        check_eq("length",    32'(length),    32'(e_len));
        check_eq("out_valid", 32'(out_valid), 32'(e_pop && phase != 0));
        check_eq("drop_err",  32'(drop_err),  32'(e_pop && phase == 0));
        if (e_pop && phase != 0) check_eq("out_flit", out_flit, mq[0]);
        acc    = v && (mq.size() != DEPTH);
        nphase = phase;
        if (phase == 0 && mq.size() != 0 && e_id == 3'b001) nphase = 1;
        if (phase == 1 && e_pop) begin
            nphase  = 2;
            len_reg = mq[0][11:0];
        end
        if (phase == 2 && e_pop && e_id == 3'b100) nphase = 0;
        phase = nphase;
        if (e_pop) void'(mq.pop_front());
        if (acc) mq.push_back(f);
        @(posedge clk);
        #1;
    endtask

    task automatic refill_gen();
        int nb;
        logic [2:0] bid;
        if ($urandom_range(0, 7) == 0) begin
            gq.push_back(mk(3'b010, 29'($urandom)));
        end else begin
            gq.push_back(mk(3'b001, {17'($urandom), 12'($urandom)}));
            nb = $urandom_range(0, 3);
            for (int i = 0; i < nb; i++) begin
                bid = ($urandom_range(0, 5) == 0) ? 3'($urandom) : 3'b010;
                if (bid == 3'b100) bid = 3'b010;
                gq.push_back(mk(bid, 29'($urandom)));
            end
            gq.push_back(mk(3'b100, 29'($urandom)));
        end
    endtask

    task automatic rand_cycle();
        logic v, acc;
        if (gq.size() == 0) refill_gen();
        v = ($urandom_range(0, 9) < 7);
        do_cycle(v, gq[0], ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0), acc);
        if (acc) void'(gq.pop_front());
    endtask

    logic acc;
    logic [FLIT_W-1:0] dir[$];

    initial begin
        rst = 1'b0; in_flit = '0; in_valid = 1'b0; grant = 1'b0; out_ready = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_in_ready",  32'(in_ready),  32'd1);
        check_eq("rst_req",       32'(req),       32'd0);
        check_eq("rst_flit_id",   32'(flit_id),   32'd0);
        check_eq("rst_length",    32'(length),    32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_drop_err",  32'(drop_err),  32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic packet, len 3, with grant and out_ready held high.
        dir = '{mk(3'b001, 29'd3), mk(3'b010, 29'h11), mk(3'b100, 29'h22)};
        foreach (dir[i]) do_cycle(1'b1, dir[i], 1'b1, 1'b1, acc);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);

        // Fill with grant low: fifth flit is held until space frees up.
        dir = '{mk(3'b001, 29'd5), mk(3'b010, 29'h1), mk(3'b010, 29'h2),
                mk(3'b010, 29'h3), mk(3'b100, 29'h4)};
        for (int i = 0; i < 4; i++) do_cycle(1'b1, dir[i], 1'b0, 1'b1, acc);
        for (int i = 0; i < 2; i++) do_cycle(1'b1, dir[4], 1'b0, 1'b1, acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) do_cycle(1'b1, dir[4], 1'b1, 1'b1, acc);
        check_eq("held_flit_accepted", 32'(acc), 32'd1);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);

        // Stray body with no header is dropped.
        do_cycle(1'b1, mk(3'b010, 29'h5a), 1'b1, 1'b1, acc);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);

        // Grant withdrawn for 4 cycles mid-packet, then restored.
        dir = '{mk(3'b001, 29'd4), mk(3'b010, 29'h7), mk(3'b010, 29'h8), mk(3'b100, 29'h9)};
        foreach (dir[i]) do_cycle(1'b1, dir[i], 1'b0, 1'b1, acc);
        do_cycle(1'b0, '0, 1'b1, 1'b1, acc);
        do_cycle(1'b0, '0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b0, 1'b1, acc);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);

        // Push plus pop at 3/4 and at 4/4 occupancy.
        dir = '{mk(3'b001, 29'd6), mk(3'b010, 29'h1), mk(3'b010, 29'h2),
                mk(3'b010, 29'h3), mk(3'b100, 29'h4)};
        for (int i = 0; i < 3; i++) do_cycle(1'b1, dir[i], 1'b0, 1'b1, acc);
        do_cycle(1'b0, '0, 1'b0, 1'b1, acc);
        do_cycle(1'b1, dir[3], 1'b1, 1'b1, acc);
        do_cycle(1'b1, dir[4], 1'b0, 1'b1, acc);
        do_cycle(1'b1, mk(3'b001, 29'd9), 1'b1, 1'b1, acc);
        check_eq("full_push_refused", 32'(acc), 32'd0);
        for (int i = 0; i < 8; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);

        for (int i = 0; i < 3000; i++) rand_cycle();

        // Asynchronous reset while sending.
        for (int i = 0; i < 300 && phase != 2; i++) rand_cycle();
        check_eq("reached_send", 32'(phase), 32'd2);
        in_valid = 1'b0; grant = 1'b1; out_ready = 1'b1;
        #2 rst = 1'b1;
        #1;
        check_eq("arst_req",       32'(req),       32'd0);
        check_eq("arst_out_valid", 32'(out_valid), 32'd0);
        check_eq("arst_flit_id",   32'(flit_id),   32'd0);
        check_eq("arst_in_ready",  32'(in_ready),  32'd1);
        check_eq("arst_length",    32'(length),    32'd0);
        model_reset();
        gq.delete();
        @(posedge clk); #1 rst = 1'b0;
        dir = '{mk(3'b001, 29'd2), mk(3'b100, 29'h3c)};
        foreach (dir[i]) do_cycle(1'b1, dir[i], 1'b1, 1'b1, acc);
        for (int i = 0; i < 4; i++) do_cycle(1'b0, '0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 1000; i++) rand_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
